// File: rtl/scan_inject_ctrl.sv
// scan_inject_ctrl
// Scan-chain fault-injection campaign controller. It resets the target,
// runs it functionally, rotates every scan chain once while corrupting one
// selected bit, runs it again, and then rotates the chains a second time
// while streaming the selected chain out serially.
module scan_inject_ctrl #(
   parameter int NUM_CHAINS = 4,
   parameter int CHAIN_LEN  = 32,
   parameter int CNT_W      = 16,
   localparam int IDX_W     = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
   localparam int POS_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IDX_W-1:0]      inj_chain,
   input  logic [POS_W-1:0]      inj_pos,
   input  logic [1:0]            inj_mode,
   input  logic [CNT_W-1:0]      run_cycles,
   input  logic [CNT_W-1:0]      post_cycles,
   output logic                  busy,
   output logic                  cfg_err,
   output logic                  sh_rst,
   output logic                  c_en,
   output logic                  sh_en,
   output logic                  err_en,
   output logic                  err_ctrl,
   input  logic [NUM_CHAINS-1:0] scan_so,
   output logic [NUM_CHAINS-1:0] scan_si,
   output logic                  dump_en,
   output logic                  ch_out,
   output logic                  ch_out_vld,
   output logic                  ch_out_done
);

   // FLUSH is the single trailing cycle that presents the last dumped bit
   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_RUN,
      S_INJ,
      S_POST,
      S_DUMP,
      S_FLUSH
   } state_t;

   localparam logic [POS_W-1:0] SH_LAST = POS_W'(CHAIN_LEN - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cyc_cnt, cyc_nxt;
   logic [POS_W-1:0]   sh_cnt, sh_nxt;

   logic [IDX_W-1:0]   chain_q;
   logic [POS_W-1:0]   pos_q;
   logic [1:0]         mode_q;
   logic [CNT_W-1:0]   run_q;
   logic [CNT_W-1:0]   post_q;
   logic               chain_ok_q;
   logic               pos_ok_q;

   logic               chain_ok_in;
   logic               pos_ok_in;
   logic               sh_last;
   logic [IDX_W-1:0]   dump_sel;
   logic               inject_now;
   logic               inject_val;

   assign chain_ok_in = 32'(inj_chain) < 32'(NUM_CHAINS);
   assign pos_ok_in   = 32'(inj_pos) < 32'(CHAIN_LEN);
   assign sh_last     = (sh_cnt == SH_LAST);
   assign dump_sel    = chain_ok_q ? chain_q : '0;
   assign inject_now  = (state == S_INJ) && (sh_cnt == pos_q) && (mode_q != 2'b00)
                        && chain_ok_q && pos_ok_q;
   assign inject_val  = (mode_q == 2'b01) ? ~scan_so[dump_sel] : mode_q[0];

   // The flipped value only exists once the target presents the bit, so
   // err_ctrl is the registered pulse gated with the value being written.
   assign err_ctrl = err_en & inject_val;

   // Campaign state and phase counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cyc_cnt <= '0;
         sh_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         cyc_cnt <= cyc_nxt;
         sh_cnt  <= sh_nxt;
      end
   end

   // Next-state sequencing; zero-length run/post phases are skipped
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      sh_nxt    = sh_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RST;
               cyc_nxt   = '0;
               sh_nxt    = '0;
            end
         end
         S_RST: begin
            if (sh_cnt == POS_W'(1)) begin
               sh_nxt    = '0;
               state_nxt = (run_q == '0) ? S_INJ : S_RUN;
            end else begin
               sh_nxt = sh_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (cyc_cnt == run_q - 1'b1) begin
               cyc_nxt   = '0;
               state_nxt = S_INJ;
            end else begin
               cyc_nxt = cyc_cnt + 1'b1;
            end
         end
         S_INJ: begin
            if (sh_last) begin
               sh_nxt    = '0;
               state_nxt = (post_q == '0) ? S_DUMP : S_POST;
            end else begin
               sh_nxt = sh_cnt + 1'b1;
            end
         end
         S_POST: begin
            if (cyc_cnt == post_q - 1'b1) begin
               cyc_nxt   = '0;
               state_nxt = S_DUMP;
            end else begin
               cyc_nxt = cyc_cnt + 1'b1;
            end
         end
         S_DUMP: begin
            if (sh_last) begin
               sh_nxt    = '0;
               state_nxt = S_FLUSH;
            end else begin
               sh_nxt = sh_cnt + 1'b1;
            end
         end
         S_FLUSH: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture the campaign configuration when a start is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_q    <= '0;
         pos_q      <= '0;
         mode_q     <= 2'b00;
         run_q      <= '0;
         post_q     <= '0;
         chain_ok_q <= 1'b0;
         pos_ok_q   <= 1'b0;
         cfg_err    <= 1'b0;
      end else if (state == S_IDLE && start) begin
         chain_q    <= inj_chain;
         pos_q      <= inj_pos;
         mode_q     <= inj_mode;
         run_q      <= run_cycles;
         post_q     <= post_cycles;
         chain_ok_q <= chain_ok_in;
         pos_ok_q   <= pos_ok_in;
         cfg_err    <= !(chain_ok_in && pos_ok_in);
      end
   end

   // Target control outputs, registered from the upcoming state so they
   // line up exactly with the phase they belong to
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= 1'b0;
         sh_rst  <= 1'b0;
         c_en    <= 1'b0;
         sh_en   <= 1'b0;
         dump_en <= 1'b0;
         err_en  <= 1'b0;
      end else begin
         busy    <= (state_nxt != S_IDLE);
         sh_rst  <= (state_nxt == S_RST);
         c_en    <= (state_nxt == S_RUN) || (state_nxt == S_POST);
         sh_en   <= (state_nxt == S_INJ) || (state_nxt == S_DUMP);
         dump_en <= (state_nxt == S_DUMP);
         err_en  <= (state_nxt == S_INJ) && (sh_nxt == pos_q) && (mode_q != 2'b00)
                    && chain_ok_q && pos_ok_q;
      end
   end

   // Serial dump stream, one cycle behind each DUMP shift
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch_out      <= 1'b0;
         ch_out_vld  <= 1'b0;
         ch_out_done <= 1'b0;
      end else begin
         ch_out      <= (state == S_DUMP) ? scan_so[dump_sel] : 1'b0;
         ch_out_vld  <= (state == S_DUMP);
         ch_out_done <= (state == S_DUMP) && sh_last;
      end
   end

   // Chains recirculate except for the single corrupted bit
   always_comb begin
      scan_si = scan_so;
      for (int k = 0; k < NUM_CHAINS; k++) begin
         if (inject_now && dump_sel == IDX_W'(k)) begin
            scan_si[k] = inject_val;
         end
      end
   end

endmodule

// File: tb/tb_scan_inject_ctrl.sv
// tb_scan_inject_ctrl
// Drives a 4x8 controller against a behavioural target (shift chains with a
// simple functional update) plus a 3x6 controller whose index ranges allow
// out-of-range configurations.
module tb_scan_inject_ctrl;

   localparam int NC  = 4;
   localparam int L   = 8;
   localparam int CW  = 16;
   localparam int BNC = 3;
   localparam int BL  = 6;
   localparam int BCW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Main controller signals
   logic          start = 1'b0;
   logic [1:0]    inj_chain = '0;
   logic [2:0]    inj_pos = '0;
   logic [1:0]    inj_mode = '0;
   logic [CW-1:0] run_cycles = '0;
   logic [CW-1:0] post_cycles = '0;
   logic busy, cfg_err, sh_rst, c_en, sh_en, err_en, err_ctrl;
   logic dump_en, ch_out, ch_out_vld, ch_out_done;
   logic [NC-1:0] scan_so, scan_si;

   // Small controller signals
   logic           b_start = 1'b0;
   logic [1:0]     b_chain = '0;
   logic [2:0]     b_pos = '0;
   logic [1:0]     b_mode = '0;
   logic [BCW-1:0] b_run = '0;
   logic [BCW-1:0] b_post = '0;
   logic b_busy, b_cfg_err, b_sh_rst, b_c_en, b_sh_en, b_err_en, b_err_ctrl;
   logic b_dump_en, b_ch_out, b_ch_out_vld, b_ch_out_done;
   logic [BNC-1:0] b_so, b_si;

   // Target models
   logic [L-1:0]  preload [NC];
   logic [L-1:0]  tgt [NC];
   logic [BL-1:0] b_init [BNC];
   logic [BL-1:0] b_tgt [BNC];
   logic          b_load = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   scan_inject_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .inj_chain(inj_chain), .inj_pos(inj_pos),
      .inj_mode(inj_mode), .run_cycles(run_cycles), .post_cycles(post_cycles),
      .busy(busy), .cfg_err(cfg_err), .sh_rst(sh_rst), .c_en(c_en), .sh_en(sh_en),
      .err_en(err_en), .err_ctrl(err_ctrl), .scan_so(scan_so), .scan_si(scan_si),
      .dump_en(dump_en), .ch_out(ch_out), .ch_out_vld(ch_out_vld),
      .ch_out_done(ch_out_done)
   );

   scan_inject_ctrl #(.NUM_CHAINS(BNC), .CHAIN_LEN(BL), .CNT_W(BCW)) u_dut_b (
      .clk(clk), .rst(rst), .start(b_start), .inj_chain(b_chain), .inj_pos(b_pos),
      .inj_mode(b_mode), .run_cycles(b_run), .post_cycles(b_post),
      .busy(b_busy), .cfg_err(b_cfg_err), .sh_rst(b_sh_rst), .c_en(b_c_en),
      .sh_en(b_sh_en), .err_en(b_err_en), .err_ctrl(b_err_ctrl), .scan_so(b_so),
      .scan_si(b_si), .dump_en(b_dump_en), .ch_out(b_ch_out),
      .ch_out_vld(b_ch_out_vld), .ch_out_done(b_ch_out_done)
   );

   // Functional update of the target's state on a clock-enabled cycle
   function automatic logic [L-1:0] evolve(input logic [L-1:0] v);
      return {v[L-2:0], v[L-1] ^ v[L/2]};
   endfunction

   // Chain bit 0 sits at the serial output
   always_comb begin
      for (int k = 0; k < NC; k++) scan_so[k] = tgt[k][0];
      for (int k = 0; k < BNC; k++) b_so[k] = b_tgt[k][0];
   end

   // Main target: reset loads preload, shift moves toward bit 0, run evolves
   always @(posedge clk) begin
      for (int k = 0; k < NC; k++) begin
         if (sh_rst)     tgt[k] <= preload[k];
         else if (sh_en) tgt[k] <= {scan_si[k], tgt[k][L-1:1]};
         else if (c_en)  tgt[k] <= evolve(tgt[k]);
      end
   end

   // Small target: static contents, shift only
   always @(posedge clk) begin
      for (int k = 0; k < BNC; k++) begin
         if (b_load)       b_tgt[k] <= b_init[k];
         else if (b_sh_en) b_tgt[k] <= {b_si[k], b_tgt[k][BL-1:1]};
      end
   end

   // One full campaign on the main controller with its expected outcome
   task automatic run_campaign(input int ch, input int pos, input int mode,
                               input int r, input int p, input bit mid_start,
                               input string name);
      logic [L-1:0] mid [NC];
      logic [L-1:0] fin [NC];
      logic [1:0]   m;
      logic [L-1:0] dump;
      logic [6:0]   obs, expv;
      logic         exp_ctrl, got_ctrl;
      bit           do_inj;
      int           t, terr, vcnt, ecnt, dd, exp_len;
      m        = mode[1:0];
      do_inj   = (m != 2'b00);
      exp_ctrl = 1'b0;
      got_ctrl = 1'b0;
      for (int k = 0; k < NC; k++) begin
         mid[k] = preload[k];
         for (int n = 0; n < r; n++) mid[k] = evolve(mid[k]);
      end
      if (do_inj) begin
         exp_ctrl = (m == 2'b01) ? ~mid[ch][pos] : m[0];
         mid[ch][pos] = exp_ctrl;
      end
      for (int k = 0; k < NC; k++) begin
         fin[k] = mid[k];
         for (int n = 0; n < p; n++) fin[k] = evolve(fin[k]);
      end
      dd      = 2 + r + L + p;
      exp_len = 2 + r + p + 2 * L + 1;

      @(negedge clk);
      inj_chain   = ch[1:0];
      inj_pos     = pos[2:0];
      inj_mode    = m;
      run_cycles  = r[CW-1:0];
      post_cycles = p[CW-1:0];
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      inj_chain   = 2'($urandom);
      inj_pos     = 3'($urandom);
      inj_mode    = 2'($urandom);
      run_cycles  = CW'($urandom);
      post_cycles = CW'($urandom);

      t = 0; terr = 0; vcnt = 0; ecnt = 0; dump = '0;
      while (busy === 1'b1 && t < exp_len + 20) begin
         expv = {t < 2,
                 (t >= 2 && t < 2 + r) || (t >= 2 + r + L && t < dd),
                 (t >= 2 + r && t < 2 + r + L) || (t >= dd && t < dd + L),
                 t >= dd && t < dd + L,
                 t >= dd + 1 && t <= dd + L,
                 t == dd + L,
                 do_inj && t == 2 + r + pos};
         obs = {sh_rst, c_en, sh_en, dump_en, ch_out_vld, ch_out_done, err_en};
         if (obs !== expv) begin
            if (terr == 0)
               $display("[TB] %s: first phase deviation at t=%0d obs=%b exp=%b", name, t, obs, expv);
            terr++;
         end
         if (ch_out_vld === 1'b1) begin
            if (vcnt < L) dump[vcnt] = ch_out;
            vcnt++;
         end
         if (err_en === 1'b1) begin
            ecnt++;
            got_ctrl = err_ctrl;
         end
         if (mid_start) begin
            if (t == 6) start = 1'b1;
            else if (t == 7) start = 1'b0;
         end
         t++;
         @(negedge clk);
      end
      start = 1'b0;

      total++;
      if (t !== exp_len) begin
         bad++; $display("[TB] FAIL %s busy_len: got %0d want %0d", name, t, exp_len);
      end
      total++;
      if (terr !== 0) begin
         bad++; $display("[TB] FAIL %s phase_timing: got %0d deviating cycles want 0", name, terr);
      end
      total++;
      if (dump !== fin[ch] || vcnt !== L) begin
         bad++; $display("[TB] FAIL %s dump: got %b (%0d bits) want %b (%0d bits)", name, dump, vcnt, fin[ch], L);
      end
      total++;
      if (ecnt !== (do_inj ? 1 : 0)) begin
         bad++; $display("[TB] FAIL %s err_en_count: got %0d want %0d", name, ecnt, do_inj ? 1 : 0);
      end
      if (do_inj) begin
         total++;
         if (got_ctrl !== exp_ctrl) begin
            bad++; $display("[TB] FAIL %s err_ctrl: got %b want %b", name, got_ctrl, exp_ctrl);
         end
      end
      total++;
      if (cfg_err !== 1'b0) begin
         bad++; $display("[TB] FAIL %s cfg_err: got %b want 0", name, cfg_err);
      end
      for (int k = 0; k < NC; k++) begin
         total++;
         if (tgt[k] !== fin[k]) begin
            bad++; $display("[TB] FAIL %s chain%0d_state: got %b want %b", name, k, tgt[k], fin[k]);
         end
      end
   endtask

   // One campaign on the small controller, whose target never evolves
   task automatic b_campaign(input int ch, input int pos, input int mode,
                             input int r, input int p, input string name);
      logic [BL-1:0] snap, exp_dump, dump;
      logic [1:0]    m;
      bit            ok;
      int            sel, t, vcnt, ecnt, exp_len;
      logic          cfg_first;
      m  = mode[1:0];
      ok = (ch < BNC) && (pos < BL);
      sel = (ch < BNC) ? ch : 0;
      @(negedge clk);
      for (int k = 0; k < BNC; k++) b_init[k] = BL'($urandom);
      b_load = 1'b1;
      @(negedge clk);
      b_load = 1'b0;
      snap     = b_tgt[sel];
      exp_dump = snap;
      if (ok && m != 2'b00) exp_dump[pos] = (m == 2'b01) ? ~snap[pos] : m[0];
      exp_len = 2 + r + p + 2 * BL + 1;

      b_chain = ch[1:0];
      b_pos   = pos[2:0];
      b_mode  = m;
      b_run   = r[BCW-1:0];
      b_post  = p[BCW-1:0];
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      cfg_first = b_cfg_err;

      t = 0; vcnt = 0; ecnt = 0; dump = '0;
      while (b_busy === 1'b1 && t < exp_len + 20) begin
         if (b_ch_out_vld === 1'b1) begin
            if (vcnt < BL) dump[vcnt] = b_ch_out;
            vcnt++;
         end
         if (b_err_en === 1'b1) ecnt++;
         t++;
         @(negedge clk);
      end

      total++;
      if (cfg_first !== !ok) begin
         bad++; $display("[TB] FAIL %s cfg_err_set: got %b want %b", name, cfg_first, !ok);
      end
      total++;
      if (t !== exp_len) begin
         bad++; $display("[TB] FAIL %s busy_len: got %0d want %0d", name, t, exp_len);
      end
      total++;
      if (ecnt !== ((ok && m != 2'b00) ? 1 : 0)) begin
         bad++; $display("[TB] FAIL %s err_en_count: got %0d want %0d", name, ecnt, (ok && m != 2'b00) ? 1 : 0);
      end
      total++;
      if (dump !== exp_dump || vcnt !== BL) begin
         bad++; $display("[TB] FAIL %s dump: got %b (%0d bits) want %b", name, dump, vcnt, exp_dump);
      end
      total++;
      if (b_cfg_err !== !ok) begin
         bad++; $display("[TB] FAIL %s cfg_err_sticky: got %b want %b", name, b_cfg_err, !ok);
      end
   endtask

   // All outputs quiet and scan_si transparent while reset is held
   task automatic check_quiet(input string name);
      logic [10:0] o;
      logic [9:0]  ob;
      o  = {busy, cfg_err, sh_rst, c_en, sh_en, err_en, err_ctrl, dump_en,
            ch_out, ch_out_vld, ch_out_done};
      ob = {b_busy, b_cfg_err, b_sh_rst, b_c_en, b_sh_en, b_err_en, b_err_ctrl,
            b_dump_en, b_ch_out_vld, b_ch_out_done};
      total++;
      if (o !== '0) begin
         bad++; $display("[TB] FAIL %s outputs: got %b want all 0", name, o);
      end
      total++;
      if (scan_si !== scan_so) begin
         bad++; $display("[TB] FAIL %s scan_si: got %b want %b", name, scan_si, scan_so);
      end
      total++;
      if (ob !== '0) begin
         bad++; $display("[TB] FAIL %s small_outputs: got %b want all 0", name, ob);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < NC; k++) preload[k] = 8'hA5;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_golden();
      for (int k = 0; k < NC; k++) preload[k] = 8'hA5;
      run_campaign(0, 0, 0, 3, 2, 1'b0, "golden");
   endtask

   task automatic test_flip();
      for (int k = 0; k < NC; k++) preload[k] = 8'hA5;
      run_campaign(2, 5, 1, 3, 2, 1'b0, "flip");
   endtask

   // Force the bit to the value it already holds
   task automatic test_force();
      logic [L-1:0] v;
      for (int k = 0; k < NC; k++) preload[k] = 8'hA5;
      v = preload[1];
      for (int n = 0; n < 3; n++) v = evolve(v);
      run_campaign(1, 4, v[4] ? 3 : 2, 3, 2, 1'b0, "force_same");
      run_campaign(3, 0, v[4] ? 2 : 3, 1, 1, 1'b0, "force_other");
   endtask

   task automatic test_zero_runs();
      for (int k = 0; k < NC; k++) preload[k] = L'($urandom);
      run_campaign(1, 7, 1, 0, 0, 1'b1, "zero_runs");
   endtask

   task automatic test_cfg_err();
      b_campaign(3, 2, 1, 2, 1, "bad_chain");
      b_campaign(1, 6, 1, 0, 0, "bad_pos");
      b_campaign(2, 4, 1, 1, 1, "valid_after");
      b_campaign(0, 0, 3, 255, 0, "long_run");
   endtask

   task automatic test_reset_mid();
      int t;
      for (int k = 0; k < NC; k++) preload[k] = L'($urandom);
      @(negedge clk);
      inj_chain = 2'd1; inj_pos = 3'd6; inj_mode = 2'b01;
      run_cycles = '0; post_cycles = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (t < 5) begin
         t++;
         @(negedge clk);
      end
      total++;
      if (sh_en !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_mid in_inj: got sh_en=%b want 1", sh_en);
      end
      rst = 1'b0;
      #1;
      check_quiet("reset_mid_now");
      repeat (3) @(negedge clk);
      check_quiet("reset_mid_held");
      rst = 1'b1;
      @(negedge clk);
      run_campaign(1, 6, 1, 2, 1, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NC; k++) preload[k] = L'($urandom);
         run_campaign($urandom_range(0, NC - 1), $urandom_range(0, L - 1),
                      $urandom_range(0, 3), $urandom_range(0, 5),
                      $urandom_range(0, 5), 1'b0, "random");
      end
   endtask

   initial begin
      for (int k = 0; k < BNC; k++) b_init[k] = '0;
      test_reset();
      test_golden();
      test_flip();
      test_force();
      test_zero_runs();
      test_cfg_err();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
